fifo_addr_ctrl: RTL and testbench

Parametrised FIFO address and occupancy controller, successor to the fixed-depth CBG address updater. It generates read and write commits, wrapping read/write addresses for an external dual-port RAM, an occupancy count, and threshold flags. Depth can be any value from 2 upward; powers of two are not required. A compile-time mode selects drop-on-full or overwrite-oldest behaviour, and sticky overflow/underflow error flags are provided.

---
 rtl/fifo_addr_ctrl.sv | 94 +++++++++
 tb/tb_fifo_addr_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_addr_ctrl.sv
// FIFO address and occupancy controller for an external dual-port RAM.
// Any DEPTH >= 2 is supported; pointers wrap by compare, not by power of two.
// OVERWRITE selects drop-on-full (0) or overwrite-oldest (1) behaviour.
module fifo_addr_ctrl #(
   parameter int DEPTH     = 16,
   parameter int AW        = $clog2(DEPTH),
   parameter int OVERWRITE = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          flush,
   input  logic          we,
   input  logic          re,
   input  logic [AW:0]   af_thresh,
   input  logic [AW:0]   ae_thresh,
   input  logic          err_clr,
   output logic          wr_ok,
   output logic          rd_ok,
   output logic [AW-1:0] wr_addr,
   output logic [AW-1:0] rd_addr,
   output logic [AW:0]   level,
   output logic          empty,
   output logic          full,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          ovf,
   output logic          udf
);

   localparam logic          OVW      = (OVERWRITE != 0);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

   logic act;
   logic drop;
   logic ovf_set;
   logic udf_set;

   // Wrap a pointer from DEPTH-1 back to 0 by compare so non power-of-two depths work.
   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      if (p == LAST_PTR) return '0;
      else               return p + AW'(1);
   endfunction

   // Flags decode only the registered level and the live thresholds.
   always_comb begin
      empty        = (level == '0);
      full         = (level == FULL_LVL);
      almost_full  = (level >= af_thresh);
      almost_empty = (level <= ae_thresh);
   end

   // Commit and error-event decode; flush overrides requests and suppresses errors.
   always_comb begin
      act     = en & ~flush;
      rd_ok   = act & re & ~empty;
      wr_ok   = act & we & (~full | re | OVW);
      drop    = act & we & full & ~re & OVW;
      ovf_set = (act & we & full & ~re & ~OVW) | drop;
      udf_set = act & re & empty;
   end

   // Pointer, level and sticky error state; everything holds while en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr <= '0;
         rd_addr <= '0;
         level   <= '0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
      end else if (en) begin
         if (flush) begin
            wr_addr <= '0;
            rd_addr <= '0;
            level   <= '0;
         end else begin
            if (wr_ok)
               wr_addr <= ptr_next(wr_addr);
            // On drop the oldest entry is discarded, so the read side moves with the write side.
            if (rd_ok | drop)
               rd_addr <= ptr_next(rd_addr);
            if (wr_ok & ~rd_ok & ~drop)
               level <= level + (AW + 1)'(1);
            else if (rd_ok & ~wr_ok)
               level <= level - (AW + 1)'(1);
         end
         // A set event in the same cycle as err_clr wins.
         ovf <= ovf_set | (ovf & ~err_clr);
         udf <= udf_set | (udf & ~err_clr);
      end
   end

endmodule

// File: tb/tb_fifo_addr_ctrl.sv
// Directed bench for fifo_addr_ctrl: two DEPTH=5 instances (drop and overwrite
// modes) share stimulus; expected values go through a scoreboard queue.
module tb_fifo_addr_ctrl;

   localparam int DEPTH = 5;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n, en, flush, we, re, err_clr;
   logic [AW:0]   af_thresh, ae_thresh;

   logic [1:0]    wr_ok_o, rd_ok_o, empty_o, full_o, af_o, ae_o, ovf_o, udf_o;
   logic [AW-1:0] wa_o [2];
   logic [AW-1:0] ra_o [2];
   logic [AW:0]   lvl_o [2];

   typedef struct {
      string       tag;
      logic [31:0] v;
   } sb_item_t;

   sb_item_t sb[$];
   int       n_checks = 0;
   int       n_err    = 0;

   fifo_addr_ctrl #(.DEPTH(DEPTH), .OVERWRITE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .we(we), .re(re),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
      .wr_ok(wr_ok_o[0]), .rd_ok(rd_ok_o[0]), .wr_addr(wa_o[0]), .rd_addr(ra_o[0]),
      .level(lvl_o[0]), .empty(empty_o[0]), .full(full_o[0]),
      .almost_full(af_o[0]), .almost_empty(ae_o[0]), .ovf(ovf_o[0]), .udf(udf_o[0])
   );

   fifo_addr_ctrl #(.DEPTH(DEPTH), .OVERWRITE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .we(we), .re(re),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
      .wr_ok(wr_ok_o[1]), .rd_ok(rd_ok_o[1]), .wr_addr(wa_o[1]), .rd_addr(ra_o[1]),
      .level(lvl_o[1]), .empty(empty_o[1]), .full(full_o[1]),
      .almost_full(af_o[1]), .almost_empty(ae_o[1]), .ovf(ovf_o[1]), .udf(udf_o[1])
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push(input string tag, input logic [31:0] v);
      sb_item_t it;
      it.tag = tag;
      it.v   = v;
      sb.push_back(it);
   endtask

   task automatic got(input logic [31:0] obs);
      sb_item_t it;
      n_checks++;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty: got %0d expected a queued value", obs);
      end else begin
         it = sb.pop_front();
         assert (obs === it.v) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", it.tag, obs, it.v);
         end
      end
   endtask

   // Expected registered state plus flags derived from the live thresholds.
   task automatic expect_state(input int d, input int lvl, input int ra, input int wa,
                               input int ov, input int ud);
      push($sformatf("u%0d level", d), 32'(lvl));
      push($sformatf("u%0d rd_addr", d), 32'(ra));
      push($sformatf("u%0d wr_addr", d), 32'(wa));
      push($sformatf("u%0d ovf", d), 32'(ov));
      push($sformatf("u%0d udf", d), 32'(ud));
      push($sformatf("u%0d empty", d), 32'(lvl == 0));
      push($sformatf("u%0d full", d), 32'(lvl == DEPTH));
      push($sformatf("u%0d almost_empty", d), 32'(lvl <= int'(ae_thresh)));
      push($sformatf("u%0d almost_full", d), 32'(lvl >= int'(af_thresh)));
   endtask

   task automatic check_state(input int d);
      got(32'(lvl_o[d]));
      got(32'(ra_o[d]));
      got(32'(wa_o[d]));
      got(32'(ovf_o[d]));
      got(32'(udf_o[d]));
      got(32'(empty_o[d]));
      got(32'(full_o[d]));
      got(32'(ae_o[d]));
      got(32'(af_o[d]));
   endtask

   task automatic state2(input int l0, input int r0, input int w0, input int o0, input int u0v,
                         input int l1, input int r1, input int w1, input int o1, input int u1v);
      expect_state(0, l0, r0, w0, o0, u0v);
      expect_state(1, l1, r1, w1, o1, u1v);
      check_state(0);
      check_state(1);
   endtask

   task automatic ok2(input int w0, input int r0, input int w1, input int r1);
      push("u0 wr_ok", 32'(w0));
      push("u0 rd_ok", 32'(r0));
      push("u1 wr_ok", 32'(w1));
      push("u1 rd_ok", 32'(r1));
      got(32'(wr_ok_o[0]));
      got(32'(rd_ok_o[0]));
      got(32'(wr_ok_o[1]));
      got(32'(rd_ok_o[1]));
   endtask

   task automatic drv(input logic w, input logic r, input logic f, input logic c);
      we = w; re = r; flush = f; err_clr = c;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; flush = 1'b0; we = 1'b0; re = 1'b0; err_clr = 1'b0;
      af_thresh = '0; ae_thresh = 4'd1;
      #2;
      // reset values, af_thresh=0 forces almost_full
      state2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      af_thresh = 4'd3;
      #1;
      state2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #8;
      rst_n = 1'b1; en = 1'b1;

      // fill to DEPTH; flags step with level
      for (int i = 0; i < DEPTH; i++) begin
         drv(1, 0, 0, 0);
         ok2(1, 0, 1, 0);
         state2(i, 0, i, 0, 0, i, 0, i, 0, 0);
         tick();
      end
      state2(5, 0, 0, 0, 0, 5, 0, 0, 0, 0);

      // write into full: rejected vs overwrite-oldest
      drv(1, 0, 0, 0);
      ok2(0, 0, 1, 0);
      tick();
      state2(5, 0, 0, 1, 0, 5, 1, 1, 1, 0);

      // simultaneous read/write at full for 7 cycles
      for (int i = 1; i <= 7; i++) begin
         drv(1, 1, 0, 0);
         ok2(1, 1, 1, 1);
         tick();
         state2(5, i % 5, i % 5, 1, 0, 5, (i + 1) % 5, (i + 1) % 5, 1, 0);
      end

      // flush at full with requests: no commits, ovf kept
      drv(1, 1, 1, 0);
      ok2(0, 0, 0, 0);
      tick();
      state2(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);

      // err_clr alone
      drv(0, 0, 0, 1);
      tick();
      state2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // we=re at empty: write only, underflow flagged
      drv(1, 1, 0, 0);
      ok2(1, 0, 1, 0);
      tick();
      state2(1, 0, 1, 0, 1, 1, 0, 1, 0, 1);

      drv(0, 1, 0, 0);
      ok2(0, 1, 0, 1);
      tick();
      state2(0, 1, 1, 0, 1, 0, 1, 1, 0, 1);

      // underflow with err_clr: set wins
      drv(0, 1, 0, 1);
      ok2(0, 0, 0, 0);
      tick();
      state2(0, 1, 1, 0, 1, 0, 1, 1, 0, 1);

      drv(0, 0, 0, 1);
      tick();
      state2(0, 1, 1, 0, 0, 0, 1, 1, 0, 0);

      // en low holds everything
      en = 1'b0;
      drv(1, 0, 0, 1);
      ok2(0, 0, 0, 0);
      tick();
      state2(0, 1, 1, 0, 0, 0, 1, 1, 0, 0);
      en = 1'b1;

      // fill to 3
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 0, 0);
         tick();
         state2(i + 1, 1, (2 + i) % 5, 0, 0, i + 1, 1, (2 + i) % 5, 0, 0);
      end

      // flush at level 3 with we=re=1
      drv(1, 1, 1, 0);
      ok2(0, 0, 0, 0);
      tick();
      state2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      drv(0, 1, 0, 0);
      tick();
      state2(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

      for (int i = 0; i < 2; i++) begin
         drv(1, 0, 0, 0);
         tick();
         state2(i + 1, 0, i + 1, 0, 1, i + 1, 0, i + 1, 0, 1);
      end

      // asynchronous reset mid-burst
      drv(1, 1, 0, 0);
      #1;
      rst_n = 1'b0;
      #1;
      state2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b1;
      drv(1, 0, 0, 0);
      ok2(1, 0, 1, 0);
      tick();
      state2(1, 0, 1, 0, 0, 1, 0, 1, 0, 0);

      // thresholds take effect without a clock edge
      af_thresh = '0;
      ae_thresh = 4'd5;
      #1;
      state2(1, 0, 1, 0, 0, 1, 0, 1, 0, 0);

      if (sb.size() != 0) begin
         n_checks++;
         n_err++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
